memory_controller: RTL and testbench
====================================

# memory_controller

Shared memory controller that sits directly downstream of two cache instances. It arbitrates their `memory_request` traffic round-robin and services each request against an internal block-organised main memory. It returns the full 16-bit block on `memory_response` and, on every write, drives the written address onto the other cache's `invalidate_address` for write-invalidate coherence.

## Interface
- `BLOCK_ADDR_BITS`, default 8: number of block-index bits.
  - Memory holds 2^BLOCK_ADDR_BITS 16-bit blocks.
  - Block index = address[BLOCK_ADDR_BITS:1]; higher address bits are ignored (aliasing).
- `MEM_LATENCY`, default 4: cycles spent in ACCESS per request. Legal range is 1 or more.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `memory_request_0` in 25: request from cache 0.
  - [24] = r/w (0 read, 1 write).
  - [23:16] = write byte.
  - [15:0] = byte address; [0] selects the byte lane.
- `memory_request_ready_0` in 1: cache 0 request valid; held high until its response is seen.
- `memory_request_1` in 25, `memory_request_ready_1` in 1: same for cache 1.
- `memory_response_0` out 16: block data to cache 0. Byte 0 is [7:0]; byte 1 is [15:8].
- `memory_response_ready_0` out 1: response valid for cache 0.
- `memory_response_1` out 16, `memory_response_ready_1` out 1: same for cache 1.
- `invalidate_address_0` out 16: address cache 0 must invalidate. Driven only by cache 1 writes.
- `invalidate_address_1` out 16: address cache 1 must invalidate. Driven only by cache 0 writes.
- `invalidate_strobe_0`, `invalidate_strobe_1` out 1: one-cycle pulse when the matching invalidate_address is updated.

## Operation
- States: IDLE, ACCESS, RESPOND.
- IDLE
  - If neither ready is high: stay.
  - If exactly one is high: grant that port.
  - If both are high: grant the port not equal to `last_grant`.
  - On grant: latch the request word and port id into internal registers, set counter = MEM_LATENCY-1, set `last_grant` = granted port, go to ACCESS.
- ACCESS
  - While the counter is nonzero, decrement it.
  - When the counter is 0, commit and go to RESPOND.
  - Read commit: response = mem[block].
  - Write commit: replace byte lane address[0] of mem[block] with the data byte. Response = updated block (cache loads the whole block on writes).
  - Write commit also updates the other port: `invalidate_address_<other>` = latched address and `invalidate_strobe_<other>` = 1 for one cycle.
- RESPOND
  - Granted port drives `memory_response_N` = response and `memory_response_ready_N` = 1.
  - Hold both until the granted `memory_request_ready_N` is sampled low.
  - Then clear `memory_response_ready_N` and go to IDLE. `memory_response_N` holds its last value.
- Requests from the non-granted port stay pending; that cache holds ready high. They are serviced on return to IDLE.
- Invalidate addresses hold their value between writes.
  - The caches react to value changes.
  - Repeated writes to the same address also pulse the strobe.

## Timing
- Reset values (reset low, async):
  - state = IDLE, counter = 0, `last_grant` = 1 (port 0 wins the first tie).
  - All `memory_response_*` = 0, all `*_ready` = 0, all `invalidate_address_*` = 0, all strobes = 0.
  - Memory array is not reset.
- Latency:
  - Request first sampled high in IDLE at edge k.
  - Commit at edge k+MEM_LATENCY.
  - `memory_response_ready_N` high after edge k+MEM_LATENCY, at the same edge as any invalidate update.
- Release:
  - `memory_response_ready_N` drops the edge after the granted request ready is sampled low.
  - The next grant is possible on the following edge.
  - Minimum gap between responses is 2 cycles beyond ACCESS.
- Simultaneous arrival in IDLE: alternate strictly via `last_grant`. A continuously requesting port cannot starve the other.
- A request ready going high in the same cycle as another port's release is not granted before IDLE.
- Reset mid-ACCESS: no write is committed and no invalidate is issued. Reset mid-RESPOND: ready drops immediately.
- MEM_LATENCY = 1: ACCESS lasts exactly one cycle.

## Test plan
- Cache 0 writes 0xAB to 0x0010, then reads 0x0011.
  - Write response = 0x??AB with lane 0 = AB.
  - `invalidate_address_1` = 0x0010 with one strobe pulse; `invalidate_address_0` unchanged.
  - Read returns a block whose [7:0] = 0xAB.
- Cache 1 writes 0xCD to 0x0011 after the above.
  - Response = 0xCDAB.
  - `invalidate_address_0` = 0x0011 with strobe.
- Both readies rise on the same edge after reset.
  - Port 0 is served first and port 1 next.
  - A second simultaneous pair is served 1 then 0.
- Latency check with MEM_LATENCY = 4: ready sampled at edge k gives response ready visible after edge k+4.
  - Response ready holds until the cache drops its ready, then clears one edge later.
- Reset asserted during ACCESS of a write of 0x55 to 0x0020.
  - All outputs are 0 immediately.
  - A later read of 0x0020 returns the prior value, not 0x55.
- Aliasing with BLOCK_ADDR_BITS = 8: a write to 0x0200 is visible on a read of 0x0000.

Source files
------------

// File: rtl/memory_controller.sv
// memory_controller: round-robin two-cache arbiter over block memory; ports clock, reset(async low), memory_request_N/_ready_N in, memory_response_N/_ready_N, invalidate_address_N/_strobe_N out
module memory_controller #(
  parameter int BLOCK_ADDR_BITS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] memory_request_0,
  input  logic        memory_request_ready_0,
  input  logic [24:0] memory_request_1,
  input  logic        memory_request_ready_1,
  output logic [15:0] memory_response_0,
  output logic        memory_response_ready_0,
  output logic [15:0] memory_response_1,
  output logic        memory_response_ready_1,
  output logic [15:0] invalidate_address_0,
  output logic [15:0] invalidate_address_1,
  output logic        invalidate_strobe_0,
  output logic        invalidate_strobe_1
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  localparam int CW = $clog2(MEM_LATENCY + 1);
  state_t state, next_state;
  logic [CW-1:0] counter;
  logic last_grant, grant, pick, any_ready, commit, release_req;
  logic [24:0] req;
  logic [15:0] mem [2**BLOCK_ADDR_BITS];
  logic [BLOCK_ADDR_BITS-1:0] idx;
  logic [15:0] blk, result;
  always_comb begin
    any_ready = memory_request_ready_0 | memory_request_ready_1;
    pick = (memory_request_ready_0 & memory_request_ready_1) ? ~last_grant : memory_request_ready_1;
    idx = req[BLOCK_ADDR_BITS:1];
    blk = mem[idx];
    result = !req[24] ? blk : req[0] ? {req[23:16], blk[7:0]} : {blk[15:8], req[23:16]};
    commit = state == ACCESS && counter == '0;
    release_req = state == RESPOND && !(grant ? memory_request_ready_1 : memory_request_ready_0);
    next_state = state == IDLE ? (any_ready ? ACCESS : IDLE) :
                 commit ? RESPOND : release_req ? IDLE : state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clock)
    if (commit && req[24]) mem[idx] <= result;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      counter <= '0;
      last_grant <= 1'b1;
      grant <= 1'b0;
      req <= '0;
      memory_response_0 <= '0;
      memory_response_1 <= '0;
      memory_response_ready_0 <= 1'b0;
      memory_response_ready_1 <= 1'b0;
      invalidate_address_0 <= '0;
      invalidate_address_1 <= '0;
      invalidate_strobe_0 <= 1'b0;
      invalidate_strobe_1 <= 1'b0;
    end else begin
      invalidate_strobe_0 <= 1'b0;
      invalidate_strobe_1 <= 1'b0;
      if (state == IDLE && any_ready) begin
        req <= pick ? memory_request_1 : memory_request_0;
        grant <= pick;
        last_grant <= pick;
        counter <= CW'(MEM_LATENCY - 1);
      end
      if (state == ACCESS && counter != '0) counter <= counter - 1'b1;
      if (commit && grant) begin
        memory_response_1 <= result;
        memory_response_ready_1 <= 1'b1;
        if (req[24]) begin
          invalidate_address_0 <= req[15:0];
          invalidate_strobe_0 <= 1'b1;
        end
      end
      if (commit && !grant) begin
        memory_response_0 <= result;
        memory_response_ready_0 <= 1'b1;
        if (req[24]) begin
          invalidate_address_1 <= req[15:0];
          invalidate_strobe_1 <= 1'b1;
        end
      end
      if (release_req && grant) memory_response_ready_1 <= 1'b0;
      if (release_req && !grant) memory_response_ready_0 <= 1'b0;
    end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed self-checking bench for memory_controller
module tb_memory_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [24:0] req0 = '0, req1 = '0;
  logic rdy0 = 1'b0, rdy1 = 1'b0;
  logic [15:0] resp0, resp1, inv0, inv1;
  logic rr0, rr1, stb0, stb1;
  int n_vec = 0, n_err = 0;
  logic [15:0] r;
  int lat;
  always #5 clock = ~clock;
  memory_controller dut (
    .clock(clock), .reset(reset),
    .memory_request_0(req0), .memory_request_ready_0(rdy0),
    .memory_request_1(req1), .memory_request_ready_1(rdy1),
    .memory_response_0(resp0), .memory_response_ready_0(rr0),
    .memory_response_1(resp1), .memory_response_ready_1(rr1),
    .invalidate_address_0(inv0), .invalidate_address_1(inv1),
    .invalidate_strobe_0(stb0), .invalidate_strobe_1(stb1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input int p, input logic w, input logic [7:0] d, input logic [15:0] a);
    @(negedge clock);
    if (p == 0) begin
      req0 = {w, d, a};
      rdy0 = 1'b1;
    end else begin
      req1 = {w, d, a};
      rdy1 = 1'b1;
    end
  endtask
  task automatic await_resp(input int p, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(p == 0 ? rr0 : rr1) && n < 20);
  endtask
  task automatic xact(input int p, input logic w, input logic [7:0] d, input logic [15:0] a, output logic [15:0] res);
    int n;
    issue(p, w, d, a);
    await_resp(p, n);
    check("latency", n, 5);
    res = p == 0 ? resp0 : resp1;
  endtask
  task automatic release_port(input int p);
    @(negedge clock);
    check("hold", p == 0 ? rr0 : rr1, 1'b1);
    check("strobe_pulse", {stb0, stb1}, 2'b00);
    if (p == 0) rdy0 = 1'b0;
    else rdy1 = 1'b0;
    @(negedge clock);
    check("clear", p == 0 ? rr0 : rr1, 1'b0);
  endtask
  task automatic check_zero(input string tag);
    check(tag, {resp0, resp1, inv0, inv1, rr0, rr1, stb0, stb1}, '0);
  endtask
  initial begin
    #1 check_zero("reset_state");
    @(negedge clock);
    reset = 1'b1;
    xact(0, 1'b1, 8'hAB, 16'h0010, r);
    check("wr_ab_lane0", r[7:0], 8'hAB);
    check("inv1_addr", inv1, 16'h0010);
    check("inv1_strobe", stb1, 1'b1);
    check("inv0_quiet", {inv0, stb0}, 17'h0);
    release_port(0);
    xact(0, 1'b0, 8'h00, 16'h0011, r);
    check("rd_0011", r[7:0], 8'hAB);
    check("inv1_hold", {inv1, stb1}, {16'h0010, 1'b0});
    release_port(0);
    xact(1, 1'b1, 8'hCD, 16'h0011, r);
    check("wr_cd_block", r, 16'hCDAB);
    check("inv0_addr", {inv0, stb0}, {16'h0011, 1'b1});
    check("inv1_quiet", stb1, 1'b0);
    release_port(1);
    xact(0, 1'b1, 8'h11, 16'h0020, r);
    check("wr_11", r[7:0], 8'h11);
    release_port(0);
    issue(0, 1'b1, 8'h55, 16'h0020);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    rdy0 = 1'b0;
    #1 check_zero("reset_mid_access");
    @(negedge clock);
    reset = 1'b1;
    xact(0, 1'b0, 8'h00, 16'h0020, r);
    check("no_commit", r[7:0], 8'h11);
    check("no_inval", {inv1, stb1}, 17'h0);
    release_port(0);
    xact(0, 1'b1, 8'h77, 16'h0200, r);
    release_port(0);
    xact(1, 1'b0, 8'h00, 16'h0000, r);
    check("alias", r[7:0], 8'h77);
    release_port(1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    req0 = {1'b0, 8'h00, 16'h0010};
    req1 = {1'b0, 8'h00, 16'h0011};
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    await_resp(0, lat);
    check("tie_first_p0", lat, 5);
    check("tie_p1_wait", rr1, 1'b0);
    release_port(0);
    rdy0 = 1'b1;
    await_resp(1, lat);
    check("rr_p1_next", rr1, 1'b1);
    check("rr_p0_wait", rr0, 1'b0);
    check("rr_p1_data", resp1, 16'hCDAB);
    release_port(1);
    await_resp(0, lat);
    check("rr_p0_last", rr0, 1'b1);
    release_port(0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
